// File: rtl/csr_bridge.sv
// Byte-command CSR bus initiator; 4 cycles from last command byte to first response byte when granted at once.
// Stalls rx while a command is in flight; tx bytes are held until accepted. Optional idle timeout: CSR_BRIDGE_TIMEOUT_EN.
module csr_bridge #(
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic        csr_read,
    output logic [2:0]  csr_modify,
    output logic [31:0] csr_wdata,
    output logic [11:0] csr_addr,
    input  logic [31:0] csr_rdata,
    input  logic        csr_valid
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_REQ, S_ACCESS, S_SAMPLE, S_RESP
    } state_t;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    state_t      state;
    logic [1:0]  op;
    logic [11:0] addr_q;
    logic [31:0] data_q;
    logic [1:0]  cnt;
    logic [31:0] old_val;
    logic [2:0]  resp_left;
    logic        opc_ok;
    logic [1:0]  opc_code;
    logic        tmo_hit;

    wire rx_fire = rx_valid & rx_ready;

    always_comb begin
        opc_ok   = 1'b1;
        opc_code = 2'd0;
        case (rx_data)
            8'h52:   opc_code = 2'd0;
            8'h57:   opc_code = 2'd1;
            8'h53:   opc_code = 2'd2;
            8'h43:   opc_code = 2'd3;
            default: opc_ok   = 1'b0;
        endcase
    end

`ifdef CSR_BRIDGE_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TW-1:0] tmo_cnt;
    wire in_cmd = (state == S_ADDR) || (state == S_DATA);

    // An accepted byte always wins over an expiry in the same cycle.
    assign tmo_hit = in_cmd && !rx_fire && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tmo_cnt <= '0;
        else if (in_cmd && !rx_fire && !tmo_hit)
            tmo_cnt <= tmo_cnt + 1'b1;
        else
            tmo_cnt <= '0;
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            op         <= 2'd0;
            addr_q     <= '0;
            data_q     <= '0;
            cnt        <= '0;
            old_val    <= '0;
            resp_left  <= '0;
            rx_ready   <= 1'b1;
            tx_valid   <= 1'b0;
            tx_data    <= '0;
            bus_req    <= 1'b0;
            csr_read   <= 1'b0;
            csr_modify <= '0;
            csr_wdata  <= '0;
            csr_addr   <= '0;
        end else begin
            case (state)
                S_IDLE: if (rx_fire) begin
                    cnt <= '0;
                    if (opc_ok) begin
                        op    <= opc_code;
                        state <= S_ADDR;
                    end else begin
                        state     <= S_RESP;
                        rx_ready  <= 1'b0;
                        tx_valid  <= 1'b1;
                        tx_data   <= NAK;
                        resp_left <= '0;
                    end
                end
                S_ADDR: if (tmo_hit) begin
                    state <= S_IDLE;
                end else if (rx_fire) begin
                    // Upper nibble of the first address byte falls off the top.
                    addr_q <= {addr_q[3:0], rx_data};
                    cnt    <= cnt + 2'd1;
                    if (cnt == 2'd1) begin
                        cnt <= '0;
                        if (op == 2'd0) begin
                            state    <= S_REQ;
                            rx_ready <= 1'b0;
                            bus_req  <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: if (tmo_hit) begin
                    state <= S_IDLE;
                end else if (rx_fire) begin
                    data_q <= {data_q[23:0], rx_data};
                    cnt    <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state    <= S_REQ;
                        rx_ready <= 1'b0;
                        bus_req  <= 1'b1;
                    end
                end
                S_REQ: if (bus_gnt) begin
                    state      <= S_ACCESS;
                    csr_read   <= 1'b1;
                    csr_modify <= {1'b0, op};
                    csr_addr   <= addr_q;
                    csr_wdata  <= data_q;
                end
                S_ACCESS: begin
                    state      <= S_SAMPLE;
                    csr_read   <= 1'b0;
                    csr_modify <= '0;
                end
                S_SAMPLE: begin
                    state    <= S_RESP;
                    bus_req  <= 1'b0;
                    tx_valid <= 1'b1;
                    old_val  <= csr_rdata;
                    if (csr_valid) begin
                        tx_data   <= ACK;
                        resp_left <= 3'd4;
                    end else begin
                        tx_data   <= NAK;
                        resp_left <= 3'd0;
                    end
                end
                S_RESP: if (tx_valid && tx_ready) begin
                    if (resp_left != 3'd0) begin
                        tx_data   <= old_val[31:24];
                        old_val   <= {old_val[23:0], 8'h00};
                        resp_left <= resp_left - 3'd1;
                    end else begin
                        tx_valid <= 1'b0;
                        rx_ready <= 1'b1;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
